mul_unit_ctrl: RTL and testbench



---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_unit_ctrl_if.sv | 31 +++
 rtl/mul_unit_ctrl_actual_mult.sv | 11 +
 rtl/mul_unit_ctrl.sv | 149 ++++++++++++++
 tb/tb_mul_unit_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types for the RV32M multiply sequencer: op codes, FSM states, word size.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: mul_op_t (funct3[1:0]), mul_state_t, MUL_XLEN, mul_mag() helper.
package mul_pkg;

   localparam int MUL_XLEN = 32;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // Magnitude of an operand that is negative only when treated as signed.
   // 0x80000000 negates to itself, which is the correct unsigned magnitude.
   function automatic logic [MUL_XLEN-1:0] mul_mag(input logic [MUL_XLEN-1:0] x,
                                                   input logic              is_neg);
      return is_neg ? ((~x) + 1'b1) : x;
   endfunction

endpackage

// File: rtl/mul_unit_ctrl_if.sv
// Request/response bundle between the execute stage and the multiply unit.
// Latency: n/a (wires only).
// Backpressure: request side gated by req_ready, response side by resp_ready.
// Ports: req_valid/req_ready/req_op/req_rs1/req_rs2/req_tag (request),
//        resp_valid/resp_ready/resp_data/resp_tag (response).
interface mul_unit_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [31:0]      req_rs1;
   logic [31:0]      req_rs2;
   logic [TAG_W-1:0] req_tag;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;

   // Issuer side (execute stage).
   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_tag
   );

   // Multiply unit side.
   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
      output req_ready, resp_valid, resp_data, resp_tag
   );
endinterface

// File: rtl/mul_unit_ctrl_actual_mult.sv
// Combinational 32x32 -> 64 unsigned multiplier (Wallace-tree in the real core).
// Latency: purely combinational; the caller holds inputs stable for a multicycle window.
// Backpressure: none.
// Ports: a_i, b_i (32-bit unsigned operands), prod_o (64-bit unsigned product).
module actual_mult (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] prod_o
);
   assign prod_o = {32'd0, a_i} * {32'd0, b_i};
endmodule

// File: rtl/mul_unit_ctrl.sv
// RV32M multiply sequencer: conditions operands, waits MULT_CYCLES, returns signed/unsigned word.
// Latency: resp_valid rises exactly MULT_CYCLES edges after the accepting edge.
// Backpressure: result held in DONE until resp_ready; no new request accepted until then.
// Ports: clk, rst_n (async active-low), flush (sync kill), busy (state != IDLE),
//        bus (slave side of mul_unit_ctrl_if: request and response handshakes).
module mul_unit_ctrl
   import mul_pkg::*;
#(
   parameter int MULT_CYCLES = 2,
   parameter int TAG_W       = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   output logic                busy,
   mul_unit_ctrl_if.slave      bus
);

   generate
      if (MULT_CYCLES < 1) begin : g_bad_cycles
         $error("mul_unit_ctrl: MULT_CYCLES must be >= 1");
      end
   endgenerate

   localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

   mul_state_t           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [MUL_XLEN-1:0]  a_q, a_d;
   logic [MUL_XLEN-1:0]  b_q, b_d;
   logic                 neg_q, neg_d;
   mul_op_t              op_q, op_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [MUL_XLEN-1:0]  resp_data_q, resp_data_d;
   logic [TAG_W-1:0]     resp_tag_q, resp_tag_d;

   logic                 req_ready;
   logic                 accept;
   mul_op_t              req_op;
   logic                 sign_a, sign_b;
   logic [63:0]          prod;
   logic [63:0]          prod_signed;

   assign req_op    = mul_op_t'(bus.req_op);
   assign req_ready = (state_q == IDLE) && !flush;
   assign accept    = bus.req_valid && req_ready;

   // Only operands treated as signed may contribute a sign.
   assign sign_a = bus.req_rs1[MUL_XLEN-1] && ((req_op == MULH) || (req_op == MULHSU));
   assign sign_b = bus.req_rs2[MUL_XLEN-1] && (req_op == MULH);

   // Operand registers feed the multiplier directly and stay frozen through CALC,
   // so this path is a MULT_CYCLES multicycle path from a_q/b_q to resp_data_q.
   actual_mult u_mult (
      .a_i    (a_q),
      .b_i    (b_q),
      .prod_o (prod)
   );

   assign prod_signed = neg_q ? ((~prod) + 64'd1) : prod;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      neg_d        = neg_q;
      op_d         = op_q;
      tag_d        = tag_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_tag_d   = resp_tag_q;

      if (flush) begin
         state_d      = IDLE;
         resp_valid_d = 1'b0;
         cnt_d        = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  a_d     = mul_mag(bus.req_rs1, sign_a);
                  b_d     = mul_mag(bus.req_rs2, sign_b);
                  neg_d   = sign_a ^ sign_b;
                  op_d    = req_op;
                  tag_d   = bus.req_tag;
                  cnt_d   = CNT_LOAD;
                  state_d = CALC;
               end
            end
            CALC: begin
               if (cnt_q == '0) begin
                  resp_data_d  = (op_q == MUL) ? prod_signed[31:0] : prod_signed[63:32];
                  resp_tag_d   = tag_q;
                  resp_valid_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_d = 1'b0;
                  state_d      = IDLE;
               end
            end
            default: begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         neg_q        <= 1'b0;
         op_q         <= MUL;
         tag_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_tag_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         neg_q        <= neg_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_tag_q   <= resp_tag_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_tag   = resp_tag_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Self-checking bench for mul_unit_ctrl: directed cases plus randomized ops vs a signed-arithmetic model.
// Latency: checks resp_valid arrives exactly MULT_CYCLES edges after accept.
// Backpressure: holds resp_ready low for random spans and checks output stability.
module tb_mul_unit_ctrl;

   localparam int MC    = 2;
   localparam int TW    = 5;

   logic clk;
   logic rst_n;
   logic flush;
   logic busy;

   int checks;
   int failures;

   mul_unit_ctrl_if #(.TAG_W(TW)) bus ();

   mul_unit_ctrl #(.MULT_CYCLES(MC), .TAG_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .busy  (busy),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: extend each operand as RV32M says, multiply as signed 66-bit integers.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [32:0] ea;
      logic signed [32:0] eb;
      logic signed [65:0] p;
      ea = (op == 2'b01 || op == 2'b10) ? $signed({a[31], a}) : $signed({1'b0, a});
      eb = (op == 2'b01) ? $signed({b[31], b}) : $signed({1'b0, b});
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Present one request at a negedge; returns after the accepting posedge (+1).
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag);
      @(negedge clk);
      check_val("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rs1   = a;
      bus.req_rs2   = b;
      bus.req_tag   = tag;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'($urandom);
      bus.req_rs1   = $urandom;
      bus.req_rs2   = $urandom;
   endtask

   // Wait (bounded) for resp_valid and check latency, data, tag.
   task automatic wait_resp(input logic [31:0] exp_data, input logic [TW-1:0] exp_tag);
      int lat;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.resp_valid) begin
            lat = i;
            break;
         end
      end
      check_val("latency", lat, MC);
      check_val("resp_data", bus.resp_data, exp_data);
      check_val("resp_tag", bus.resp_tag, exp_tag);
   endtask

   // Hold resp_ready low for 'hold' cycles, then complete the handshake.
   task automatic drain(input int hold, input logic [31:0] exp_data, input logic [TW-1:0] exp_tag);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold_valid", bus.resp_valid, 1);
         check_val("hold_data", bus.resp_data, exp_data);
         check_val("hold_tag", bus.resp_tag, exp_tag);
         check_val("hold_req_ready", bus.req_ready, 0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      check_val("post_hs_valid", bus.resp_valid, 0);
      check_val("post_hs_req_ready", bus.req_ready, 1);
      check_val("post_hs_busy", busy, 0);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag, input int hold, input logic [31:0] exp);
      issue(op, a, b, tag);
      wait_resp(exp, tag);
      drain(hold, exp, tag);
   endtask

   logic [31:0] corners [6];

   initial begin
      checks   = 0;
      failures = 0;
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'hFFFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'h7FFF_FFFF;
      corners[5] = 32'h8000_0001;

      rst_n          = 1'b0;
      flush          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_op     = 2'b00;
      bus.req_rs1    = '0;
      bus.req_rs2    = '0;
      bus.req_tag    = '0;
      bus.resp_ready = 1'b0;
      #23;
      check_val("rst_resp_valid", bus.resp_valid, 0);
      check_val("rst_resp_data", bus.resp_data, 0);
      check_val("rst_resp_tag", bus.resp_tag, 0);
      check_val("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_req_ready", bus.req_ready, 1);

      // Directed cases.
      run_op(2'b00, 32'd7, 32'd6, 5'd3, 0, 32'h0000_002A);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 32'h0000_0000);
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 32'hFFFF_FFFE);
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 32'hFFFF_FFFF);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 32'h0000_0001);
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd6, 0, 32'h4000_0000);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd7, 0, 32'h0000_0000);
      run_op(2'b01, 32'h8000_0000, 32'h0000_0001, 5'd8, 0, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd1234, 32'd5678, 5'd9, 5, ref_mul(2'b11, 32'd1234, 32'd5678));

      // Flush one cycle into CALC: op must vanish.
      begin
         int seen;
         issue(2'b00, 32'd9, 32'd9, 5'd10);
         @(negedge clk);
         flush = 1'b1;
         #1;
         check_val("flush_req_ready", bus.req_ready, 0);
         @(posedge clk);
         #1;
         flush = 1'b0;
         check_val("flush_busy", busy, 0);
         seen = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
         end
         check_val("flush_no_resp", seen, 0);
      end

      // Request alongside flush while idle must not be accepted.
      @(negedge clk);
      flush         = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b00;
      @(posedge clk);
      #1;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      check_val("flush_blocks_accept", busy, 0);

      run_op(2'b00, 32'd3, 32'd5, 5'd11, 0, 32'h0000_000F);

      // Async reset while in DONE.
      issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12);
      wait_resp(ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 5'd12);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_resp_valid", bus.resp_valid, 0);
      check_val("arst_resp_data", bus.resp_data, 0);
      check_val("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("arst_req_ready", bus.req_ready, 1);
      run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd13, 0, 32'h0000_0001);

      // Randomized ops against the reference.
      for (int n = 0; n < 60; n++) begin
         logic [1:0]    op;
         logic [31:0]   a;
         logic [31:0]   b;
         logic [TW-1:0] tg;
         op = 2'($urandom);
         a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         tg = TW'($urandom);
         run_op(op, a, b, tg, $urandom_range(0, 3), ref_mul(op, a, b));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
